icache_fill_fsm: RTL
====================

Name: icache_fill_fsm

Overview:
Miss-handling controller between the instruction cache and the multi-cycle main memory. It feeds the fetch stage of the cpu. On a fetch miss it stalls the pipeline, streams one 8-word block from the pipelined memory, writes each returned word into the cache data array, and writes the tag on the last word. The data memory side reuses the same block with a separate instance.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block (power of two); offset width OFF_W = log2(WORDS_PER_BLOCK) = 3
ADDR_W, 16, word-address width
DATA_W, 16, memory/cache data word width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
miss_detected  in  1  cache lookup missed this cycle
miss_address  in  ADDR_W  word address that missed
fsm_busy  out  1  stall request to the pc / pipeline
mem_read_en  out  1  read request to main memory, one word per cycle
memory_address  out  ADDR_W  address of the current read request
memory_data_valid  in  1  memory returns one word this cycle, in request order
memory_data  in  DATA_W  returned word
write_data_array  out  1  write strobe to the cache data array
cache_word_offset  out  OFF_W  word slot written this cycle
cache_data  out  DATA_W  word written (memory_data passed through)
write_tag_array  out  1  one-cycle tag/valid write strobe
fill_tag  out  ADDR_W  latched block base address for the tag write

Behaviour:
- States: IDLE, FILL. Reset (asynchronous, any time) forces IDLE with req_cnt=0, rcv_cnt=0, base=0. All registered outputs reset to 0.
- IDLE: fsm_busy = miss_detected (combinational, so the stall is immediate). On miss_detected, next state is FILL and base <= miss_address with the low OFF_W bits cleared. memory_data_valid is ignored.
- FILL, request side: mem_read_en = (req_cnt < WORDS_PER_BLOCK); memory_address = base + req_cnt. req_cnt increments each cycle while requesting. Requests issue on 8 consecutive cycles starting the first FILL cycle.
- FILL, return side: on memory_data_valid, write_data_array=1, cache_word_offset=rcv_cnt[OFF_W-1:0], cache_data=memory_data, and rcv_cnt increments. When memory_data_valid is not asserted, write_data_array=0.
- Last word: when memory_data_valid and rcv_cnt==WORDS_PER_BLOCK-1, write_tag_array=1 in that same cycle and next state is IDLE; both counters clear.
- fsm_busy = 1 throughout FILL, including the tag-write cycle. It drops the cycle after the tag write unless a new miss is present.
- miss_detected during FILL is ignored; the cache re-presents the miss after the fill if still relevant.
- Returns may overlap requests (memory latency below 8 is allowed). A return with req_cnt==rcv_cnt is a memory protocol violation, flagged by an assertion only.
- Address arithmetic is modulo 2^ADDR_W. Base is aligned, so a block never wraps: base 0xFFF8 covers 0xFFF8..0xFFFF.
- fill_tag = base, held stable from the first FILL cycle until the next miss is accepted.
- Reset mid-fill: abandon the fill, no tag write, and late memory returns are ignored in IDLE. The cache block stays invalid because no tag was written.
- Counters are OFF_W+1 bits wide so that the value 8 is representable.

Decomposition:
- Shared package icache_pkg: WORDS_PER_BLOCK, OFF_W, fill-state encoding (IDLE=1'b0, FILL=1'b1), block-align mask function.
- One natural sub-module: fill_counter (clear / increment / terminal-count, OFF_W+1 bits), instantiated twice, for requests and for returns.

Test Plan:
- Basic fill, latency 4: miss at 0x1234 in cycle 0 -> requests 0x1230..0x1237 in cycles 1-8; data writes offsets 0..7 in cycles 5-12; write_tag_array=1 only in cycle 12 with fill_tag=0x1230; fsm_busy high cycles 0-12, low in cycle 13.
- Gapped returns: valid deasserted on alternate cycles -> offsets still 0..7 in order, exactly 8 data writes, tag write coincides with the 8th valid.
- Top-of-memory: miss at 0xFFFD -> addresses 0xFFF8..0xFFFF, no 0x0000 request, fill_tag=0xFFF8.
- Reset mid-fill: assert rst after 3 returns -> all outputs 0 immediately, state IDLE, no tag write; later stray valids produce no writes.
- Miss ignored during FILL: pulse miss_detected with 0x4000 mid-fill of 0x1230 -> base stays 0x1230; a second fill starts only if miss is present in IDLE afterwards.
- Back-to-back misses: new miss present in the cycle after the tag write -> fsm_busy stays high (0 idle gaps in stall), next fill starts in the following cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache miss/fill controller.
//   WORDS_PER_BLOCK : words per cache block (power of two)
//   OFF_W           : word-offset width inside a block
//   CNT_W           : fill counter width (one extra bit so a full block count fits)
//   fill_state_e    : controller state encoding
//   block_align()   : clears the word-offset bits of an address
package icache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W           = OFF_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Works on a 32-bit container; callers narrow the result to their width.
    function automatic logic [31:0] block_align(input logic [31:0] addr);
        return addr & ~32'(WORDS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/icache_fill_fsm_fill_counter.sv
// Small up-counter used for the request and return sides of a block fill.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count up by one
//   cnt      : current count
//   tc       : cnt equals TERM
module fill_counter #(
    parameter int W    = 4,
    parameter int TERM = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + W'(1);
    end

    assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: on a miss, stalls fetch, streams one block
// from pipelined main memory, writes each returned word into the data array
// and writes the tag together with the last word.
//   clk, rst            : clock, asynchronous active-high reset
//   miss_detected       : lookup missed this cycle
//   miss_address        : word address that missed
//   fsm_busy            : stall request to the pc / pipeline
//   mem_read_en         : one-word read request to memory
//   memory_address      : address of that request
//   memory_data_valid   : memory returns a word (in request order)
//   memory_data         : returned word
//   write_data_array    : data array write strobe
//   cache_word_offset   : word slot being written
//   cache_data          : word being written
//   write_tag_array     : tag/valid write strobe (last word cycle)
//   fill_tag            : block base address of the current/last fill
module icache_fill_fsm
    import icache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              write_data_array,
    output logic [OFF_W-1:0]  cache_word_offset,
    output logic [DATA_W-1:0] cache_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_tag
);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic              load_base;
    logic              fill_done;

    logic [CNT_W-1:0]  req_cnt, rcv_cnt;
    logic              req_all_sent;  // all words of the block requested
    logic              rcv_last;      // next return is the last word

    fill_counter #(.W(CNT_W), .TERM(WORDS_PER_BLOCK)) u_req_cnt (
        .clk (clk),
        .rst (rst),
        .clr (fill_done),
        .inc (mem_read_en),
        .cnt (req_cnt),
        .tc  (req_all_sent)
    );

    // Terminal count one short of a block flags the final return.
    fill_counter #(.W(CNT_W), .TERM(WORDS_PER_BLOCK - 1)) u_rcv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (fill_done),
        .inc (write_data_array),
        .cnt (rcv_cnt),
        .tc  (rcv_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_base) base_q <= ADDR_W'(block_align(32'(miss_address)));
        end
    end

    always_comb begin
        state_d           = state_q;
        load_base         = 1'b0;
        fill_done         = 1'b0;
        fsm_busy          = 1'b0;
        mem_read_en       = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        cache_word_offset = '0;
        cache_data        = '0;
        write_tag_array   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Combinational stall so fetch holds in the miss cycle itself.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d   = FILL;
                    load_base = 1'b1;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (!req_all_sent) begin
                    mem_read_en    = 1'b1;
                    memory_address = base_q + ADDR_W'(req_cnt);
                end
                if (memory_data_valid) begin
                    write_data_array  = 1'b1;
                    cache_word_offset = rcv_cnt[OFF_W-1:0];
                    cache_data        = memory_data;
                    if (rcv_last) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fill_tag = base_q;

`ifndef SYNTHESIS
    // Memory may only return words that were already requested.
    a_no_early_return: assert property (@(posedge clk) disable iff (rst)
        (state_q == FILL && memory_data_valid) |-> (req_cnt != rcv_cnt));
`endif

endmodule
